// File: rtl/cycle_seq_pkg.sv
// Shared types and defaults for the CPU cycle-stretch sequencer.
package cycle_seq_pkg;

  localparam int unsigned DEF_NUM_REQ  = 2;
  localparam int unsigned DEF_CNT_W    = 4;
  localparam int unsigned DEF_BASE_DIV = 4;
  localparam int unsigned STALL_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    STRETCH = 2'd2
  } seq_state_e;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above rr_ptr wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [PTR_W-1:0]   win_idx_c,
  output logic               any_c
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [PTR_W:0]       sum;
  logic                 found;

  // Rotate so that bit 0 is the requester currently holding priority.
  always_comb begin
    req_dbl = {req, req} >> rr_ptr;
    req_rot = req_dbl[NUM_REQ-1:0];
  end

  always_comb begin
    found     = 1'b0;
    sum       = '0;
    win_idx_c = '0;
    gnt_c     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (PTR_W+1)'(i);
        if (sum >= (PTR_W+1)'(NUM_REQ)) begin
          sum = sum - (PTR_W+1)'(NUM_REQ);
        end
      end
    end
    win_idx_c = PTR_W'(sum);
    if (found) begin
      gnt_c = NUM_REQ'(1) << win_idx_c;
    end
    any_c = found;
  end

endmodule

// File: rtl/cycle_stretch_sequencer.sv
// CPU cycle-enable sequencer with round-robin requester stretch.
// Optional stall statistics port enabled by defining CYCLE_SEQ_STATS_EN.
module cycle_stretch_sequencer
  import cycle_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned BASE_DIV = DEF_BASE_DIV
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     cpu_en,
  output logic                     ext_clk,
  output logic                     busy
`ifdef CYCLE_SEQ_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0]   stall_count
`endif
);

  localparam int unsigned PTR_W = ptr_width(NUM_REQ);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(BASE_DIV - 1);

  seq_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   scnt, scnt_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic               cpu_en_nxt;
  logic               ext_clk_nxt;
  logic               busy_nxt;

  logic [NUM_REQ-1:0] arb_gnt_c;
  logic [PTR_W-1:0]   arb_idx_c;
  logic               arb_any_c;
  logic [CNT_W-1:0]   win_len_c;
  logic [CNT_W-1:0]   load_len_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .gnt_c     (arb_gnt_c),
    .win_idx_c (arb_idx_c),
    .any_c     (arb_any_c)
  );

  // Stretch length of the winner; a zero length still costs one clk.
  always_comb begin
    win_len_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt_c[i]) begin
        win_len_c = req_len[i*CNT_W +: CNT_W];
      end
    end
    load_len_c = (win_len_c == '0) ? CNT_W'(1) : win_len_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      scnt    <= '0;
      rr_ptr  <= '0;
      grant   <= '0;
      cpu_en  <= 1'b0;
      ext_clk <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      scnt    <= scnt_nxt;
      rr_ptr  <= rr_ptr_nxt;
      grant   <= grant_nxt;
      cpu_en  <= cpu_en_nxt;
      ext_clk <= ext_clk_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    scnt_nxt   = scnt;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant;
    cpu_en_nxt = 1'b0;
    busy_nxt   = busy;

    case (state)
      IDLE: begin
        if (run) begin
          state_nxt = COUNT;
          cnt_nxt   = '0;
        end
      end

      COUNT: begin
        if (!run) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == TERM) begin
          cnt_nxt = '0;
          if (arb_any_c) begin
            // Boundary is withheld; the winner owns the stretch.
            state_nxt  = STRETCH;
            grant_nxt  = arb_gnt_c;
            scnt_nxt   = load_len_c;
            busy_nxt   = 1'b1;
            rr_ptr_nxt = (arb_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx_c + PTR_W'(1);
          end else begin
            cpu_en_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      STRETCH: begin
        if (scnt == CNT_W'(1)) begin
          // A stretch always finishes with its boundary, even when run has dropped.
          cpu_en_nxt = 1'b1;
          grant_nxt  = '0;
          busy_nxt   = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = run ? COUNT : IDLE;
        end else begin
          scnt_nxt = scnt - CNT_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    ext_clk_nxt = ext_clk ^ cpu_en_nxt;
  end

`ifdef CYCLE_SEQ_STATS_EN
  // Saturating count of clks spent stretching.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (state == STRETCH && stall_count != '1) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cycle_stretch_sequencer.sv
// Scoreboard bench for cycle_stretch_sequencer; expected cpu_en pulses and grants are queued up front.
module tb_cycle_stretch_sequencer;

  typedef struct {
    int   edge_n;
    logic ext;
  } pulse_t;

  typedef struct {
    int         edge_n;
    logic [1:0] g;
  } gnt_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [1:0] req = '0;
  logic [7:0] req_len = '0;
  logic [1:0] grant;
  logic       cpu_en;
  logic       ext_clk;
  logic       busy;
`ifdef CYCLE_SEQ_STATS_EN
  logic [15:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;
  pulse_t pq[$];
  gnt_t   gq[$];

  always #5 clk = ~clk;

  cycle_stretch_sequencer #(
    .NUM_REQ  (2),
    .CNT_W    (4),
    .BASE_DIV (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .req     (req),
    .req_len (req_len),
    .grant   (grant),
    .cpu_en  (cpu_en),
    .ext_clk (ext_clk),
    .busy    (busy)
`ifdef CYCLE_SEQ_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; req = '0; req_len = '0;
    pq.delete(); gq.delete();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; req = '0; req_len = '0;
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || cpu_en !== 1'b0 || ext_clk !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got grant=%b cpu_en=%b ext_clk=%b busy=%b want 00 0 0 0", grant, cpu_en, ext_clk, busy);
    end
`ifdef CYCLE_SEQ_STATS_EN
    checks++;
    if (stall_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall got %0d want 0", stall_count);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    pulse_t p;
    do_reset();
    pq.push_back('{4, 1'b1}); pq.push_back('{8, 1'b0}); pq.push_back('{12, 1'b1});
    run = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      step();
      checks++;
      if (busy !== 1'b0 || grant !== 2'b00) begin
        errors++;
        $display("FAIL free_idle_grant edge %0d got busy=%b grant=%b want 0 00", e, busy, grant);
      end
      if (cpu_en === 1'b1) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL free_pulse unexpected at edge %0d", e);
        end else begin
          p = pq.pop_front();
          if (e != p.edge_n || ext_clk !== p.ext) begin
            errors++;
            $display("FAIL free_pulse got edge %0d ext %b want edge %0d ext %b", e, ext_clk, p.edge_n, p.ext);
          end
        end
      end
    end
    checks++;
    if (pq.size() != 0) begin
      errors++;
      $display("FAIL free_missing got %0d pulses outstanding want 0", pq.size());
    end
  endtask

  task automatic test_stretch();
    pulse_t p;
    gnt_t   g;
    logic [1:0] prev_g = 2'b00;
    logic exp_busy;
    do_reset();
    pq.push_back('{4, 1'b1}); pq.push_back('{11, 1'b0}); pq.push_back('{15, 1'b1});
    gq.push_back('{8, 2'b10});
    run = 1'b1;
    for (int e = 0; e <= 16; e++) begin
      step();
      exp_busy = (e >= 8 && e <= 10);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL stretch_busy edge %0d got %b want %b", e, busy, exp_busy);
      end
      if (grant !== 2'b00 && prev_g === 2'b00) begin
        checks++;
        if (gq.size() == 0) begin
          errors++;
          $display("FAIL stretch_grant unexpected %b at edge %0d", grant, e);
        end else begin
          g = gq.pop_front();
          if (e != g.edge_n || grant !== g.g) begin
            errors++;
            $display("FAIL stretch_grant got %b at edge %0d want %b at edge %0d", grant, e, g.g, g.edge_n);
          end
        end
      end
      prev_g = grant;
      if (cpu_en === 1'b1) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL stretch_pulse unexpected at edge %0d", e);
        end else begin
          p = pq.pop_front();
          if (e != p.edge_n || ext_clk !== p.ext) begin
            errors++;
            $display("FAIL stretch_pulse got edge %0d ext %b want edge %0d ext %b", e, ext_clk, p.edge_n, p.ext);
          end
        end
      end
`ifdef CYCLE_SEQ_STATS_EN
      if (e == 11 || e == 16) begin
        checks++;
        if (stall_count !== 16'd3) begin
          errors++;
          $display("FAIL stretch_stall edge %0d got %0d want 3", e, stall_count);
        end
      end
`endif
      if (e == 5) begin req = 2'b10; req_len = {4'd3, 4'd0}; end
      if (e == 8) req = 2'b00;
      if (e == 9) req_len = {4'd1, 4'd0};
    end
    checks++;
    if (pq.size() != 0 || gq.size() != 0) begin
      errors++;
      $display("FAIL stretch_missing got %0d pulses %0d grants outstanding want 0", pq.size(), gq.size());
    end
  endtask

  task automatic test_round_robin();
    pulse_t p;
    gnt_t   g;
    logic [1:0] prev_g = 2'b00;
    do_reset();
    pq.push_back('{6, 1'b1}); pq.push_back('{12, 1'b0}); pq.push_back('{18, 1'b1});
    gq.push_back('{4, 2'b01}); gq.push_back('{10, 2'b10}); gq.push_back('{16, 2'b01});
    req = 2'b11; req_len = {4'd2, 4'd2};
    run = 1'b1;
    for (int e = 0; e <= 19; e++) begin
      step();
      checks++;
      if (grant === 2'b11) begin
        errors++;
        $display("FAIL rr_onehot edge %0d got %b want one-hot", e, grant);
      end
      if (grant !== 2'b00 && prev_g === 2'b00) begin
        checks++;
        if (gq.size() == 0) begin
          errors++;
          $display("FAIL rr_grant unexpected %b at edge %0d", grant, e);
        end else begin
          g = gq.pop_front();
          if (e != g.edge_n || grant !== g.g) begin
            errors++;
            $display("FAIL rr_grant got %b at edge %0d want %b at edge %0d", grant, e, g.g, g.edge_n);
          end
        end
      end
      prev_g = grant;
      if (cpu_en === 1'b1) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL rr_pulse unexpected at edge %0d", e);
        end else begin
          p = pq.pop_front();
          if (e != p.edge_n || ext_clk !== p.ext) begin
            errors++;
            $display("FAIL rr_pulse got edge %0d ext %b want edge %0d ext %b", e, ext_clk, p.edge_n, p.ext);
          end
        end
      end
    end
    checks++;
    if (pq.size() != 0 || gq.size() != 0) begin
      errors++;
      $display("FAIL rr_missing got %0d pulses %0d grants outstanding want 0", pq.size(), gq.size());
    end
  endtask

  task automatic test_zero_len();
    pulse_t p;
    do_reset();
    pq.push_back('{4, 1'b1}); pq.push_back('{9, 1'b0}); pq.push_back('{13, 1'b1});
    run = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      step();
      if (e == 8) begin
        checks++;
        if (grant !== 2'b01 || busy !== 1'b1) begin
          errors++;
          $display("FAIL zero_grant got grant=%b busy=%b want 01 1", grant, busy);
        end
      end
      if (cpu_en === 1'b1) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL zero_pulse unexpected at edge %0d", e);
        end else begin
          p = pq.pop_front();
          if (e != p.edge_n || ext_clk !== p.ext) begin
            errors++;
            $display("FAIL zero_pulse got edge %0d ext %b want edge %0d ext %b", e, ext_clk, p.edge_n, p.ext);
          end
        end
      end
      if (e == 5) begin req = 2'b01; req_len = {4'd5, 4'd0}; end
      if (e == 8) req = 2'b00;
    end
    checks++;
    if (pq.size() != 0) begin
      errors++;
      $display("FAIL zero_missing got %0d pulses outstanding want 0", pq.size());
    end
  endtask

  task automatic test_run_stop();
    pulse_t p;
    do_reset();
    pq.push_back('{4, 1'b1}); pq.push_back('{11, 1'b0});
    run = 1'b1;
    for (int e = 0; e <= 22; e++) begin
      step();
      if (cpu_en === 1'b1) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL stop_pulse unexpected at edge %0d", e);
        end else begin
          p = pq.pop_front();
          if (e != p.edge_n || ext_clk !== p.ext) begin
            errors++;
            $display("FAIL stop_pulse got edge %0d ext %b want edge %0d ext %b", e, ext_clk, p.edge_n, p.ext);
          end
        end
      end
      if (e == 5) begin req = 2'b10; req_len = {4'd3, 4'd0}; end
      if (e == 8) req = 2'b00;
      if (e == 9) run = 1'b0;
    end
    checks++;
    if (pq.size() != 0 || ext_clk !== 1'b0 || busy !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL stop_final got pending=%0d ext=%b busy=%b grant=%b want 0 0 0 00", pq.size(), ext_clk, busy, grant);
    end
  endtask

  task automatic test_reset_mid();
    pulse_t p;
    do_reset();
    pq.push_back('{4, 1'b1});
    run = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      step();
      if (cpu_en === 1'b1) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL rstmid_pulse unexpected at edge %0d", e);
        end else begin
          p = pq.pop_front();
          if (e != p.edge_n || ext_clk !== p.ext) begin
            errors++;
            $display("FAIL rstmid_pulse got edge %0d ext %b want edge %0d ext %b", e, ext_clk, p.edge_n, p.ext);
          end
        end
      end
      if (e == 5) begin req = 2'b10; req_len = {4'd3, 4'd0}; end
    end
    checks++;
    if (busy !== 1'b1 || grant !== 2'b10 || ext_clk !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got busy=%b grant=%b ext=%b want 1 10 1", busy, grant, ext_clk);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || cpu_en !== 1'b0 || ext_clk !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got grant=%b busy=%b cpu_en=%b ext=%b want 00 0 0 0", grant, busy, cpu_en, ext_clk);
    end
`ifdef CYCLE_SEQ_STATS_EN
    checks++;
    if (stall_count !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_stall got %0d want 0", stall_count);
    end
`endif
    @(negedge clk);
    reset = 1'b0; run = 1'b0; req = '0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stretch();
    test_round_robin();
    test_zero_len();
    test_run_stop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
